// File: rtl/gtfwizard_raw_qpll_seq.sv
// Power-up, reset and lock supervisor for up to two QPLLs of a GTF common block.
// Every PLL gets its own lock/refclklost synchronisers, FSM and counters, all
// clocked by the free-running DRP clock. Outputs are registered together with
// the state, so each output reflects the state the FSM has just entered.
module gtfwizard_raw_qpll_seq #(
  parameter int N_QPLL        = 2,
  parameter int PD_CYCLES     = 16,
  parameter int RST_CYCLES    = 32,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 64,
  parameter int MAX_RETRY     = 3
) (
  input  logic                  gtf_cm_drpclk,
  input  logic                  gtf_cm_reset,
  input  logic [N_QPLL-1:0]     gtf_cm_qpll_en,
  input  logic [N_QPLL-1:0]     gtf_cm_qpll_lock,
  input  logic [N_QPLL-1:0]     gtf_cm_qpll_refclklost,
  input  logic [N_QPLL-1:0]     gtf_cm_qpll_fault_clr,
  output logic [N_QPLL-1:0]     gtf_cm_qpll_pd,
  output logic [N_QPLL-1:0]     gtf_cm_qpll_reset,
  output logic [N_QPLL-1:0]     gtf_cm_qpll_ready,
  output logic [N_QPLL-1:0]     gtf_cm_qpll_fault,
  output logic [N_QPLL-1:0]     gtf_cm_qpll_relock_evt,
  output logic [4*N_QPLL-1:0]   gtf_cm_qpll_retry_cnt
);

  localparam logic [15:0] LP_PD     = 16'(PD_CYCLES);
  localparam logic [15:0] LP_RST_M1 = 16'(RST_CYCLES - 1);
  localparam logic [15:0] LP_TO_M1  = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] LP_STB    = 16'(STABLE_CYCLES);
  localparam logic [3:0]  LP_MAXR   = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_OFF, S_PWRUP, S_WAIT, S_STABLE, S_READY, S_FAULT
  } state_t;

  // Output pattern for a state: {pd, reset, ready, fault}
  function automatic logic [3:0] f_outs(input state_t s);
    case (s)
      S_OFF:            f_outs = 4'b1100;
      S_PWRUP:          f_outs = 4'b0100;
      S_WAIT, S_STABLE: f_outs = 4'b0000;
      S_READY:          f_outs = 4'b0010;
      S_FAULT:          f_outs = 4'b1101;
      default:          f_outs = 4'b1100;
    endcase
  endfunction

  for (genvar g = 0; g < N_QPLL; g++) begin : g_pll
    logic [1:0]  r_lock_sync;
    logic [1:0]  r_rcl_sync;
    state_t      r_state;
    logic [3:0]  r_outs;
    logic        r_relock;
    logic [15:0] r_dwell;
    logic [15:0] r_timer;
    logic [15:0] r_stable;
    logic [3:0]  r_retry;
    logic        w_lock_s;
    logic        w_lost;
    logic        w_timeout;
    logic [3:0]  w_retry_inc;

    assign w_lock_s    = r_lock_sync[1];
    assign w_lost      = !w_lock_s || r_rcl_sync[1];
    assign w_timeout   = (r_timer >= LP_TO_M1);
    assign w_retry_inc = r_retry + 4'd1;

    // Two-flop synchronisers for the asynchronous lock and refclklost inputs
    always_ff @(posedge gtf_cm_drpclk) begin
      if (gtf_cm_reset) begin
        r_lock_sync <= 2'b00;
        r_rcl_sync  <= 2'b00;
      end else begin
        r_lock_sync <= {r_lock_sync[0], gtf_cm_qpll_lock[g]};
        r_rcl_sync  <= {r_rcl_sync[0], gtf_cm_qpll_refclklost[g]};
      end
    end

    // Per-PLL sequencer; r_dwell times both the OFF dwell and the PWRUP reset hold
    always_ff @(posedge gtf_cm_drpclk) begin
      if (gtf_cm_reset) begin
        r_state  <= S_OFF;
        r_outs   <= f_outs(S_OFF);
        r_relock <= 1'b0;
        r_dwell  <= '0;
        r_timer  <= '0;
        r_stable <= '0;
        r_retry  <= '0;
      end else begin
        r_relock <= 1'b0;
        if (r_state == S_FAULT) begin
          // Only an explicit clear leaves FAULT; enable is deliberately ignored
          if (gtf_cm_qpll_fault_clr[g]) begin
            r_state <= S_OFF;
            r_outs  <= f_outs(S_OFF);
            r_retry <= '0;
            r_dwell <= '0;
          end
        end else if (!gtf_cm_qpll_en[g]) begin
          // Disable overrides everything, but a lock loss in READY is still reported
          r_state  <= S_OFF;
          r_outs   <= f_outs(S_OFF);
          r_retry  <= '0;
          r_dwell  <= '0;
          r_relock <= (r_state == S_READY) && w_lost;
        end else begin
          case (r_state)
            S_OFF: begin
              if (r_dwell >= LP_PD) begin
                r_state <= S_PWRUP;
                r_outs  <= f_outs(S_PWRUP);
                r_dwell <= '0;
                r_timer <= '0;
              end else begin
                r_dwell <= r_dwell + 16'd1;
              end
            end
            S_PWRUP: begin
              if (r_dwell >= LP_RST_M1) begin
                r_state <= S_WAIT;
                r_outs  <= f_outs(S_WAIT);
              end else begin
                r_dwell <= r_dwell + 16'd1;
              end
            end
            S_WAIT, S_STABLE: begin
              // Timeout takes priority over any lock progress in the same cycle
              if (w_timeout) begin
                r_retry <= w_retry_inc;
                if (w_retry_inc >= LP_MAXR) begin
                  r_state <= S_FAULT;
                  r_outs  <= f_outs(S_FAULT);
                end else begin
                  r_state <= S_PWRUP;
                  r_outs  <= f_outs(S_PWRUP);
                  r_dwell <= '0;
                  r_timer <= '0;
                end
              end else begin
                r_timer <= r_timer + 16'd1;
                if (r_state == S_WAIT) begin
                  if (w_lock_s) begin
                    r_state  <= S_STABLE;
                    r_outs   <= f_outs(S_STABLE);
                    r_stable <= '0;
                  end
                end else if (!w_lock_s) begin
                  r_state <= S_WAIT;
                  r_outs  <= f_outs(S_WAIT);
                end else if (r_stable >= LP_STB) begin
                  r_state <= S_READY;
                  r_outs  <= f_outs(S_READY);
                end else begin
                  r_stable <= r_stable + 16'd1;
                end
              end
            end
            S_READY: begin
              if (w_lost) begin
                r_relock <= 1'b1;
                r_retry  <= '0;
                r_state  <= S_PWRUP;
                r_outs   <= f_outs(S_PWRUP);
                r_dwell  <= '0;
                r_timer  <= '0;
              end
            end
            default: begin
              r_state <= S_OFF;
              r_outs  <= f_outs(S_OFF);
              r_dwell <= '0;
            end
          endcase
        end
      end
    end

    assign gtf_cm_qpll_pd[g]               = r_outs[3];
    assign gtf_cm_qpll_reset[g]            = r_outs[2];
    assign gtf_cm_qpll_ready[g]            = r_outs[1];
    assign gtf_cm_qpll_fault[g]            = r_outs[0];
    assign gtf_cm_qpll_relock_evt[g]       = r_relock;
    assign gtf_cm_qpll_retry_cnt[4*g +: 4] = r_retry;
  end

endmodule

// File: tb/tb_gtfwizard_raw_qpll_seq.sv
// Bench for gtfwizard_raw_qpll_seq with default parameters (two PLLs).
// The stimulus process schedules expected per-PLL output snapshots keyed by
// clock cycle; a separate monitor pops and compares them on the falling edge.
module tb_gtfwizard_raw_qpll_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] en, lock, rcl, clr;
  logic [1:0] pd, prst, rdy, flt, rlk;
  logic [7:0] rcnt;

  always #5 clk = ~clk;

  gtfwizard_raw_qpll_seq dut (
    .gtf_cm_drpclk          (clk),
    .gtf_cm_reset           (rst),
    .gtf_cm_qpll_en         (en),
    .gtf_cm_qpll_lock       (lock),
    .gtf_cm_qpll_refclklost (rcl),
    .gtf_cm_qpll_fault_clr  (clr),
    .gtf_cm_qpll_pd         (pd),
    .gtf_cm_qpll_reset      (prst),
    .gtf_cm_qpll_ready      (rdy),
    .gtf_cm_qpll_fault      (flt),
    .gtf_cm_qpll_relock_evt (rlk),
    .gtf_cm_qpll_retry_cnt  (rcnt)
  );

  // Cycle number = count of rising edges seen so far
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int         cyc;
    int         pll;
    logic [8:0] exp;
    string      name;
  } chk_t;
  chk_t q[$];

  // {pd, reset, ready, fault, relock_evt, retry_cnt[3:0]}
  function automatic logic [8:0] snap(int p);
    return {pd[p], prst[p], rdy[p], flt[p], rlk[p], rcnt[4*p +: 4]};
  endfunction

  function automatic void exp_at(int c, int p, logic e_pd, logic e_rst, logic e_rdy,
                                 logic e_flt, logic e_rlk, logic [3:0] e_rc, string nm);
    chk_t e;
    int   i;
    e.cyc  = c;
    e.pll  = p;
    e.exp  = {e_pd, e_rst, e_rdy, e_flt, e_rlk, e_rc};
    e.name = nm;
    i = 0;
    while (i < q.size() && q[i].cyc <= c) i++;
    q.insert(i, e);
  endfunction

  task automatic wait_to(int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: compares the scheduled snapshot for the current cycle
  initial begin
    forever begin
      chk_t e;
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        n_chk++;
        if (e.cyc != cyc) begin
          n_err++;
          $display("FAIL %s pll%0d: check for cycle %0d not reached (now %0d)", e.name, e.pll, e.cyc, cyc);
        end else if (snap(e.pll) !== e.exp) begin
          n_err++;
          $display("FAIL %s pll%0d cycle %0d: pd,rst,rdy,flt,rlk,retry got %b required %b",
                   e.name, e.pll, cyc, snap(e.pll), e.exp);
        end
      end
    end
  end

  // Watchdog
  initial begin
    wait (cyc > 20000);
    $display("FAIL watchdog: cycle %0d exceeded budget 20000", cyc);
    $fatal(1, "bench did not finish");
  end

  // Stimulus
  initial begin
    rst = 1'b1; en = 2'b11; lock = 2'b00; rcl = 2'b00; clr = 2'b00;

    // Reset state for both PLLs
    exp_at(3, 0, 1, 1, 0, 0, 0, 4'd0, "reset_p0");
    exp_at(3, 1, 1, 1, 0, 0, 0, 4'd0, "reset_p1");
    // Nominal start: reset released at cycle 5, pd falls 17 later, reset 49 later
    exp_at(21, 0, 1, 1, 0, 0, 0, 4'd0, "pd_hold");
    exp_at(22, 0, 0, 1, 0, 0, 0, 4'd0, "pd_fall");
    exp_at(22, 1, 0, 1, 0, 0, 0, 4'd0, "pd_fall");
    exp_at(53, 0, 0, 1, 0, 0, 0, 4'd0, "rst_hold");
    exp_at(54, 0, 0, 0, 0, 0, 0, 4'd0, "rst_fall");
    exp_at(54, 1, 0, 0, 0, 0, 0, 4'd0, "rst_fall");
    // Lock already synchronised at WAIT_LOCK entry (54): STABLE at 55, READY 65 later
    exp_at(119, 0, 0, 0, 0, 0, 0, 4'd0, "rdy_pre");
    exp_at(120, 0, 0, 0, 1, 0, 0, 4'd0, "rdy_rise");
    wait_to(5);
    rst = 1'b0;
    wait_to(15);
    lock[0] = 1'b1;

    // PLL1 never locks: timeouts 4096 cycles after each WAIT_LOCK entry
    exp_at(4149, 1, 0, 0, 0, 0, 0, 4'd0, "to1_pre");
    exp_at(4150, 1, 0, 1, 0, 0, 0, 4'd1, "to1_retry");
    exp_at(4181, 1, 0, 1, 0, 0, 0, 4'd1, "to1_pwrup");
    exp_at(4182, 1, 0, 0, 0, 0, 0, 4'd1, "to1_wait");
    exp_at(8277, 1, 0, 0, 0, 0, 0, 4'd1, "to2_pre");
    exp_at(8278, 1, 0, 1, 0, 0, 0, 4'd2, "to2_retry");
    exp_at(12405, 1, 0, 0, 0, 0, 0, 4'd2, "to3_pre");
    exp_at(12406, 1, 1, 1, 0, 1, 0, 4'd3, "to3_fault");
    exp_at(12406, 0, 0, 0, 1, 0, 0, 4'd0, "p0_indep");

    // PLL0 lock loss in READY: seen at 203 (2 sync + 1), resequence to WAIT_LOCK at 235
    exp_at(202, 0, 0, 0, 1, 0, 0, 4'd0, "loss_pre");
    exp_at(203, 0, 0, 1, 0, 0, 1, 4'd0, "loss_evt");
    exp_at(204, 0, 0, 1, 0, 0, 0, 4'd0, "loss_evt_end");
    exp_at(234, 0, 0, 1, 0, 0, 0, 4'd0, "reseq_pwrup");
    exp_at(235, 0, 0, 0, 0, 0, 0, 4'd0, "reseq_wait");
    // Lock returns at 300: ready 2+1+64+1 = 68 cycles later
    exp_at(367, 0, 0, 0, 0, 0, 0, 4'd0, "lat_pre");
    exp_at(368, 0, 0, 0, 1, 0, 0, 4'd0, "lat_rdy");
    wait_to(200);
    lock[0] = 1'b0;
    wait_to(300);
    lock[0] = 1'b1;

    // refclklost in READY, then a 5-cycle lock glitch after 40 stable cycles
    exp_at(402, 0, 0, 0, 1, 0, 0, 4'd0, "rcl_pre");
    exp_at(403, 0, 0, 1, 0, 0, 1, 4'd0, "rcl_evt");
    exp_at(435, 0, 0, 0, 0, 0, 0, 4'd0, "rcl_wait");
    exp_at(501, 0, 0, 0, 0, 0, 0, 4'd0, "glitch_delay");
    exp_at(548, 0, 0, 0, 0, 0, 0, 4'd0, "glitch_pre");
    exp_at(549, 0, 0, 0, 1, 0, 0, 4'd0, "glitch_rdy");
    wait_to(400);
    rcl[0] = 1'b1;
    wait_to(410);
    rcl[0] = 1'b0;
    wait_to(476);
    lock[0] = 1'b0;
    wait_to(481);
    lock[0] = 1'b1;

    // fault_clr outside FAULT is ignored
    exp_at(12431, 0, 0, 0, 1, 0, 0, 4'd0, "clr_ignored");
    exp_at(12432, 0, 0, 0, 1, 0, 0, 4'd0, "clr_ignored2");
    // PLL1 in FAULT ignores enable; fault_clr restarts with a fresh dwell
    exp_at(12455, 1, 1, 1, 0, 1, 0, 4'd3, "fault_en_ign");
    exp_at(12470, 1, 1, 1, 0, 1, 0, 4'd3, "fault_hold");
    exp_at(12471, 1, 1, 1, 0, 0, 0, 4'd0, "fault_clr");
    exp_at(12487, 1, 1, 1, 0, 0, 0, 4'd0, "clr_dwell");
    exp_at(12488, 1, 0, 1, 0, 0, 0, 4'd0, "clr_pd_fall");
    exp_at(12585, 1, 0, 0, 0, 0, 0, 4'd0, "clr_rdy_pre");
    exp_at(12586, 1, 0, 0, 1, 0, 0, 4'd0, "clr_rdy");
    wait_to(12430);
    clr[0] = 1'b1;
    wait_to(12431);
    clr[0] = 1'b0;
    wait_to(12450);
    en[1] = 1'b0;
    wait_to(12460);
    en[1] = 1'b1;
    wait_to(12470);
    clr[1] = 1'b1;
    wait_to(12471);
    clr[1] = 1'b0;
    wait_to(12480);
    lock[1] = 1'b1;

    // PLL0 dropped to WAIT_LOCK, then disabled there while PLL1 is READY
    exp_at(12503, 0, 0, 1, 0, 0, 1, 4'd0, "p0_loss2");
    exp_at(12535, 0, 0, 0, 0, 0, 0, 4'd0, "p0_wait2");
    exp_at(12600, 0, 0, 0, 0, 0, 0, 4'd0, "dis_pre");
    exp_at(12601, 0, 1, 1, 0, 0, 0, 4'd0, "dis_off");
    exp_at(12600, 1, 0, 0, 1, 0, 0, 4'd0, "p1_keep_a");
    exp_at(12601, 1, 0, 0, 1, 0, 0, 4'd0, "p1_keep_b");
    exp_at(12610, 1, 0, 0, 1, 0, 0, 4'd0, "p1_keep_c");
    wait_to(12500);
    lock[0] = 1'b0;
    wait_to(12600);
    en[0] = 1'b0;

    // PLL1: lock loss and disable in the same cycle resolve to OFF with relock_evt
    exp_at(12651, 1, 0, 0, 1, 0, 0, 4'd0, "both_pre");
    exp_at(12652, 1, 1, 1, 0, 0, 1, 4'd0, "both_off_evt");
    exp_at(12653, 1, 1, 1, 0, 0, 0, 4'd0, "both_evt_end");
    // PLL0 re-enabled from OFF: dwell counted from enable
    exp_at(12716, 0, 1, 1, 0, 0, 0, 4'd0, "reen_dwell");
    exp_at(12717, 0, 0, 1, 0, 0, 0, 4'd0, "reen_pd_fall");
    wait_to(12649);
    lock[1] = 1'b0;
    wait_to(12651);
    en[1] = 1'b0;
    wait_to(12700);
    en[0] = 1'b1;

    wait_to(12730);
    @(negedge clk);
    while (q.size() > 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s pll%0d: scheduled check for cycle %0d never evaluated", q[0].name, q[0].pll, q[0].cyc);
      void'(q.pop_front());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/gtfwizard_raw_qpll_seq.md
# gtfwizard_raw_qpll_seq

Parametrised power-up, reset and lock supervisor for up to two QPLLs of a GTF common block. It sits between the example top's control logic and the GTF common wrapper. For each PLL it sequences PD and RESET, qualifies the asynchronous QPLLxLOCK, retries on lock timeout and latches a fault after repeated failures. Each PLL channel is an independent copy of the same FSM and counters, and all of them run on the free-running DRP clock.

## Interface

Parameters:
- N_QPLL, 2: number of supervised PLLs; legal values 1..2.
- PD_CYCLES, 16: minimum cycles spent in OFF (PD asserted) before power-up.
- RST_CYCLES, 32: cycles RESET is held after PD is released.
- LOCK_TIMEOUT, 4096: cycles allowed from RESET release to READY.
- STABLE_CYCLES, 64: consecutive synchronised-lock cycles required before READY.
- MAX_RETRY, 3: timeouts tolerated before FAULT; legal values 1..15.
- All count parameters are ≥1 and ≤65535. Counters are 16 bits wide.

Ports:
- gtf_cm_drpclk  in  1  free-running clock.
- gtf_cm_reset  in  1  synchronous, active-high reset.
- gtf_cm_qpll_en  in  N_QPLL  per-PLL enable (level).
- gtf_cm_qpll_lock  in  N_QPLL  QPLLxLOCK; asynchronous.
- gtf_cm_qpll_refclklost  in  N_QPLL  QPLLxREFCLKLOST; asynchronous.
- gtf_cm_qpll_fault_clr  in  N_QPLL  single-cycle fault clear.
- gtf_cm_qpll_pd  out  N_QPLL  drives QPLLxPD.
- gtf_cm_qpll_reset  out  N_QPLL  drives QPLLxRESET.
- gtf_cm_qpll_ready  out  N_QPLL  qualified lock.
- gtf_cm_qpll_fault  out  N_QPLL  latched failure.
- gtf_cm_qpll_relock_evt  out  N_QPLL  one-cycle pulse on loss of lock from READY.
- gtf_cm_qpll_retry_cnt  out  4*N_QPLL  per-PLL retry count; PLL i occupies [4i+3:4i].

## Operation

Input handling:
- lock and refclklost each pass through a 2-flop synchroniser (lock_s, rcl_s). The synchroniser flops reset to 0.

Per-PLL states:
- OFF: pd=1, reset=1, dwell counter increments.
  - Exits to PWRUP when en=1 and the dwell counter ≥ PD_CYCLES.
- PWRUP: pd=0, reset=1.
  - Exits to WAIT_LOCK after exactly RST_CYCLES cycles.
  - Entry clears the lock timer.
- WAIT_LOCK: pd=0, reset=0, lock timer runs.
  - lock_s=1 → STABLE, with the stable counter cleared.
- STABLE: pd=0, reset=0, lock timer keeps running.
  - lock_s=1 increments the stable counter; when it reaches STABLE_CYCLES → READY.
  - lock_s=0 → WAIT_LOCK; the lock timer is not cleared.
- Timeout: the lock timer reaching LOCK_TIMEOUT in WAIT_LOCK or STABLE increments retry_cnt.
  - If the new count equals MAX_RETRY → FAULT.
  - Otherwise → PWRUP.
- READY: ready=1. On lock_s=0 or rcl_s=1:
  - relock_evt pulses for one cycle;
  - retry_cnt is cleared to 0;
  - state → PWRUP.
- FAULT: pd=1, reset=1, fault=1, ready=0.
  - en is ignored. fault_clr → OFF with retry_cnt cleared and the dwell counter cleared.

Boundary conditions:
- en=0 in any state except FAULT → OFF on the next cycle; dwell counter cleared, retry_cnt cleared.
- fault_clr outside FAULT is ignored.
- In READY, a simultaneous lock loss and en=0 resolves to OFF; relock_evt still pulses.
- A timeout and lock_s=1 in the same cycle: the timeout wins.
- retry_cnt saturates at MAX_RETRY.
- Each PLL FSM is fully independent. With N_QPLL=1, only index 0 exists.

## Timing

- All outputs are registered and decoded from the state register, so they change the cycle after a state transition.
- Values during and after gtf_cm_reset, for every PLL:
  - state OFF, counters cleared;
  - pd=1, reset=1;
  - ready=0, fault=0, relock_evt=0, retry_cnt=0.
- OFF dwell: with en already high, pd deasserts PD_CYCLES+1 cycles after reset release.
- PWRUP: reset deasserts RST_CYCLES cycles after pd deasserts.
- lock → ready latency: 2 synchroniser cycles + 1 transition into STABLE + STABLE_CYCLES + 1 output register.
- lock loss → ready low: 2 synchroniser cycles + 1 cycle.
  - relock_evt is high during the same cycle ready first reads 0.
  - reset reasserts in that same cycle.
- Timeout period: LOCK_TIMEOUT cycles counted from the first WAIT_LOCK cycle.

## Test plan

1. Nominal lock:
   - Stimulus: reset, then en=1; lock rises 10 cycles after reset deasserts.
   - Required: pd falls at cycle 17 and reset falls at cycle 49, both counted from reset release; ready rises 2+1+64+1 cycles after lock; retry_cnt=0.
2. No lock:
   - Stimulus: lock held at 0.
   - Required: retry_cnt steps 1→2, each followed by a new PWRUP; on the third timeout fault=1 and pd=1; ready stays 0 throughout.
3. Lock glitch during STABLE:
   - Stimulus: lock drops for 5 cycles at stable count 40.
   - Required: ready is delayed; it asserts only after 64 fresh consecutive lock_s cycles; no retry increment as long as the timer stays below 4096.
4. Loss in READY:
   - Stimulus: lock falls while ready=1.
   - Required: relock_evt pulses for exactly one cycle; ready=0 and reset=1; retry_cnt=0; ready returns after a full resequence.
5. Mid-sequence disable with N_QPLL=2:
   - Stimulus: en[0] dropped during WAIT_LOCK while PLL1 is READY.
   - Required: PLL0 enters OFF (pd=1) on the next cycle; PLL1 outputs are unchanged.
6. Fault clear:
   - Stimulus: from FAULT, pulse fault_clr with en=1.
   - Required: fault=0 and retry_cnt=0 on the next cycle; the nominal sequence restarts with a PD_CYCLES dwell.
